// File: rtl/decode_pipe_stage.sv
// Decode stage: register file, immediate/control decode, ID/EX register and load-use stall.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into the decode read.
module decode_pipe_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instructionF,
    input  logic [XLEN-1:0] PCF,
    input  logic            ValidF,
    input  logic            FlushD,
    input  logic            RegWriteW,
    input  logic [4:0]      WriteAddressW,
    input  logic [XLEN-1:0] writeDataW,
    output logic            StallF,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemReadE,
    output logic            MemWriteE,
    output logic            JtypeE,
    output logic            BranchE,
    output logic            PCSelectE,
    output logic            ImmSelectE,
    output logic            IllegalE,
    output logic [5:0]      ALUSelectE,
    output logic [4:0]      WriteAddressE,
    output logic [XLEN-1:0] ReadOut1E,
    output logic [XLEN-1:0] ReadOut2E,
    output logic [XLEN-1:0] ImmGenOutE,
    output logic [XLEN-1:0] PCE
);
    localparam int unsigned ADDR_W = $clog2(REG_COUNT);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            jtype;
        logic            branch;
        logic            pcSel;
        logic            immSel;
        logic            illegal;
        logic [5:0]      alu;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1Val;
        logic [XLEN-1:0] rs2Val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } eRegT;

    logic [XLEN-1:0] regFile [REG_COUNT];
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1Data, rs2Data, imm;
    logic [5:0]      alu;
    logic            isR, isI, isS, isB, isU, isJ, known;
    logic            useRs1, useRs2, useRd, illegal;
    logic            memRd, memWr, jtype, branch, pcSel;
    logic            wbEn, hazard, bubble;
    eRegT            eD, eQ;

    assign opcode = instructionF[6:0];
    assign funct3 = instructionF[14:12];
    assign rd     = instructionF[11:7];
    assign rs1    = instructionF[19:15];
    assign rs2    = instructionF[24:20];

    // Writes to x0 or beyond the implemented register count are dropped.
    assign wbEn = RegWriteW && (WriteAddressW != 5'd0) && (32'(WriteAddressW) < REG_COUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regFile <= '{default: '0};
        end else if (wbEn) begin
            regFile[WriteAddressW[ADDR_W-1:0]] <= writeDataW;
        end
    end

    always_comb begin
        rs1Data = '0;
        rs2Data = '0;
        if (rs1 != 5'd0 && 32'(rs1) < REG_COUNT) rs1Data = regFile[rs1[ADDR_W-1:0]];
        if (rs2 != 5'd0 && 32'(rs2) < REG_COUNT) rs2Data = regFile[rs2[ADDR_W-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (RegWriteW && WriteAddressW == rs1 && rs1 != 5'd0) rs1Data = writeDataW;
        if (RegWriteW && WriteAddressW == rs2 && rs2 != 5'd0) rs2Data = writeDataW;
`endif
    end

    always_comb begin
        isR    = 1'b0;
        isI    = 1'b0;
        isS    = 1'b0;
        isB    = 1'b0;
        isU    = 1'b0;
        isJ    = 1'b0;
        memRd  = 1'b0;
        memWr  = 1'b0;
        jtype  = 1'b0;
        branch = 1'b0;
        pcSel  = 1'b0;
        alu    = 6'd0;
        case (opcode)
            OpReg:    begin isR = 1'b1; alu = {instructionF[25], instructionF[30], funct3, 1'b0}; end
            OpImm:    begin
                isI = 1'b1;
                alu = {1'b0, (funct3 == 3'b101) & instructionF[30], funct3, 1'b0};
            end
            OpLoad:   begin isI = 1'b1; memRd = 1'b1; end
            OpStore:  begin isS = 1'b1; memWr = 1'b1; end
            OpBranch: begin isB = 1'b1; branch = 1'b1; pcSel = 1'b1; alu = {2'b10, funct3, 1'b0}; end
            OpLui:    begin isU = 1'b1; alu = 6'b000001; end
            OpAuipc:  begin isU = 1'b1; pcSel = 1'b1; end
            OpJal:    begin isJ = 1'b1; jtype = 1'b1; pcSel = 1'b1; end
            OpJalr:   begin isI = 1'b1; jtype = 1'b1; end
            default:  ;
        endcase
    end

    assign known  = isR | isI | isS | isB | isU | isJ;
    assign useRs1 = !(isU || isJ);
    assign useRs2 = !(isI || isU || isJ);
    assign useRd  = isR | isI | isU | isJ;
    assign illegal = !known
        || (useRs1 && 32'(rs1) >= REG_COUNT)
        || (useRs2 && 32'(rs2) >= REG_COUNT)
        || (useRd && 32'(rd) >= REG_COUNT);

    always_comb begin
        imm = '0;
        if (isI) imm = XLEN'($signed(instructionF[31:20]));
        if (isS) imm = XLEN'($signed({instructionF[31:25], instructionF[11:7]}));
        if (isB) imm = XLEN'($signed({instructionF[31], instructionF[7], instructionF[30:25],
                                      instructionF[11:8], 1'b0}));
        if (isU) imm = XLEN'($signed({instructionF[31:12], 12'b0}));
        if (isJ) imm = XLEN'($signed({instructionF[31], instructionF[19:12], instructionF[20],
                                      instructionF[30:21], 1'b0}));
    end

    // Only sources the instruction format actually reads can create a load-use hazard.
    assign hazard = ValidE && MemReadE && (WriteAddressE != 5'd0)
        && ((useRs1 && rs1 == WriteAddressE) || (useRs2 && rs2 == WriteAddressE));
    assign StallF = hazard && !FlushD;
    assign bubble = FlushD || hazard || !ValidF;

    always_comb begin
        eD = '0;
        if (!bubble) begin
            eD.valid    = 1'b1;
            eD.illegal  = illegal;
            eD.regWrite = useRd && (rd != 5'd0) && !illegal;
            eD.memRead  = memRd && !illegal;
            eD.memWrite = memWr && !illegal;
            eD.jtype    = jtype && !illegal;
            eD.branch   = branch && !illegal;
            eD.pcSel    = pcSel;
            eD.immSel   = known && !isR && !isB;
            eD.alu      = alu;
            eD.rd       = rd;
            eD.rs1Val   = rs1Data;
            eD.rs2Val   = rs2Data;
            eD.imm      = imm;
            eD.pc       = PCF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eQ <= '0;
        end else begin
            eQ <= eD;
        end
    end

    assign {ValidE, RegWriteE, MemReadE, MemWriteE, JtypeE, BranchE, PCSelectE, ImmSelectE,
            IllegalE, ALUSelectE, WriteAddressE, ReadOut1E, ReadOut2E, ImmGenOutE, PCE} = eQ;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Randomized and directed bench for decode_pipe_stage against a rule-level reference model.
module tb_decode_pipe_stage;
    localparam logic [31:0] AddX5X1X1  = 32'h001082B3;
    localparam logic [31:0] AddiX6X1   = 32'h00A08313;
    localparam logic [31:0] SwM4       = 32'hFE50AE23;
    localparam logic [31:0] LuiX7      = 32'h123453B7;
    localparam logic [31:0] LwX3       = 32'h00012183;
    localparam logic [31:0] AddX4X3X1  = 32'h00118233;
    localparam logic [31:0] AddiX4X0   = 32'h00100213;
    localparam logic [31:0] JalX1      = 32'h010000EF;
    localparam logic [31:0] AddX17     = 32'h002088B3;
    localparam logic [31:0] AddX5X4X0  = 32'h000202B3;
    localparam logic [6:0]  Ops [10] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37,
                                         7'h17, 7'h6F, 7'h67};

    typedef struct packed {
        logic valid, regWrite, memRead, memWrite, jtype, branch, pcSel, immSel, illegal;
        logic [5:0]  alu;
        logic [4:0]  wa;
        logic [31:0] r1, r2, imm, pc;
    } eStateT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instructionF = '0, PCF = '0, writeDataW = '0;
    logic        ValidF = 1'b0, FlushD = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  WriteAddressW = '0;

    logic        StallF, ValidE, RegWriteE, MemReadE, MemWriteE, JtypeE, BranchE;
    logic        PCSelectE, ImmSelectE, IllegalE;
    logic [5:0]  ALUSelectE;
    logic [4:0]  WriteAddressE;
    logic [31:0] ReadOut1E, ReadOut2E, ImmGenOutE, PCE;

    logic        stallF16, validE16, regWriteE16, memReadE16, memWriteE16, jtypeE16, branchE16;
    logic        pcSelectE16, immSelectE16, illegalE16;
    logic [5:0]  aluSelectE16;
    logic [4:0]  writeAddressE16;
    logic [31:0] readOut1E16, readOut2E16, immGenOutE16, pcE16;

    int          total = 0, bad = 0;
    logic [31:0] mRegs [32];
    eStateT      expE = '0;
    logic        stallObs, expStall;

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(32), .REG_COUNT(32)) dut (
        .clk(clk), .reset(reset), .instructionF(instructionF), .PCF(PCF), .ValidF(ValidF),
        .FlushD(FlushD), .RegWriteW(RegWriteW), .WriteAddressW(WriteAddressW),
        .writeDataW(writeDataW), .StallF(StallF), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemReadE(MemReadE), .MemWriteE(MemWriteE), .JtypeE(JtypeE), .BranchE(BranchE),
        .PCSelectE(PCSelectE), .ImmSelectE(ImmSelectE), .IllegalE(IllegalE),
        .ALUSelectE(ALUSelectE), .WriteAddressE(WriteAddressE), .ReadOut1E(ReadOut1E),
        .ReadOut2E(ReadOut2E), .ImmGenOutE(ImmGenOutE), .PCE(PCE)
    );

    decode_pipe_stage #(.XLEN(32), .REG_COUNT(16)) dut16 (
        .clk(clk), .reset(reset), .instructionF(instructionF), .PCF(PCF), .ValidF(ValidF),
        .FlushD(FlushD), .RegWriteW(RegWriteW), .WriteAddressW(WriteAddressW),
        .writeDataW(writeDataW), .StallF(stallF16), .ValidE(validE16), .RegWriteE(regWriteE16),
        .MemReadE(memReadE16), .MemWriteE(memWriteE16), .JtypeE(jtypeE16), .BranchE(branchE16),
        .PCSelectE(pcSelectE16), .ImmSelectE(immSelectE16), .IllegalE(illegalE16),
        .ALUSelectE(aluSelectE16), .WriteAddressE(writeAddressE16), .ReadOut1E(readOut1E16),
        .ReadOut2E(readOut2E16), .ImmGenOutE(immGenOutE16), .PCE(pcE16)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic eStateT actualE();
        eStateT a;
        a = {ValidE, RegWriteE, MemReadE, MemWriteE, JtypeE, BranchE, PCSelectE, ImmSelectE,
             IllegalE, ALUSelectE, WriteAddressE, ReadOut1E, ReadOut2E, ImmGenOutE, PCE};
        return a;
    endfunction

    function automatic byte fmtOf(input logic [6:0] op);
        case (op)
            7'h33:               return "R";
            7'h13, 7'h03, 7'h67: return "I";
            7'h23:               return "S";
            7'h63:               return "B";
            7'h37, 7'h17:        return "U";
            7'h6F:               return "J";
            default:             return "?";
        endcase
    endfunction

    function automatic longint sext(input longint v, input int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (RegWriteW && WriteAddressW == idx) return writeDataW;
`endif
        return mRegs[idx];
    endfunction

    function automatic eStateT modelDecode(input logic [31:0] ins, input logic [31:0] pc);
        eStateT e;
        byte f;
        logic [6:0] op;
        int f3;
        longint imm;
        e = '0;
        f = fmtOf(ins[6:0]);
        op = ins[6:0];
        f3 = int'(ins[14:12]);
        e.valid = 1'b1;
        e.wa = ins[11:7];
        e.pc = pc;
        e.r1 = readModel(ins[19:15]);
        e.r2 = readModel(ins[24:20]);
        case (f)
            "I": imm = sext(longint'(ins[31:20]), 12);
            "S": imm = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            "B": imm = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            "U": imm = longint'(ins[31:12]) * 4096;
            "J": imm = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            default: imm = 0;
        endcase
        e.imm = 32'(imm);
        case (op)
            7'h33:   e.alu = 6'(32 * int'(ins[25]) + 16 * int'(ins[30]) + 2 * f3);
            7'h13:   e.alu = 6'((f3 == 5 ? 16 * int'(ins[30]) : 0) + 2 * f3);
            7'h63:   e.alu = 6'(32 + 2 * f3);
            7'h37:   e.alu = 6'd1;
            default: e.alu = 6'd0;
        endcase
        e.memRead  = (op == 7'h03);
        e.memWrite = (op == 7'h23);
        e.jtype    = (op == 7'h6F || op == 7'h67);
        e.branch   = (op == 7'h63);
        e.pcSel    = (op == 7'h17 || op == 7'h6F || op == 7'h63);
        e.immSel   = (f != "?" && f != "R" && f != "B");
        e.regWrite = (f == "R" || f == "I" || f == "U" || f == "J") && ins[11:7] != 5'd0;
        e.illegal  = (f == "?");
        return e;
    endfunction

    function automatic bit modelHazard();
        byte f;
        bit u1, u2;
        f = fmtOf(instructionF[6:0]);
        u1 = !(f == "U" || f == "J");
        u2 = !(f == "I" || f == "U" || f == "J");
        return expE.valid && expE.memRead && expE.wa != 5'd0
            && ((u1 && instructionF[19:15] == expE.wa) || (u2 && instructionF[24:20] == expE.wa));
    endfunction

    // One clock: check StallF mid-cycle, advance the model, check the E register after the edge.
    task automatic cycle();
        eStateT nxt;
        bit hz;
        @(negedge clk);
        hz = modelHazard();
        expStall = hz && !FlushD;
        stallObs = StallF;
        check("StallF", StallF, expStall);
        nxt = (FlushD || hz || !ValidF) ? '0 : modelDecode(instructionF, PCF);
        if (RegWriteW && WriteAddressW != 5'd0) mRegs[WriteAddressW] = writeDataW;
        expE = nxt;
        @(posedge clk);
        #1;
        check("E regs", actualE(), expE);
    endtask

    task automatic setIn(input logic [31:0] ins, input logic v, input logic fl, input logic rw,
                         input logic [4:0] wa, input logic [31:0] wd);
        instructionF = ins;
        PCF = PCF + 32'd4;
        ValidF = v;
        FlushD = fl;
        RegWriteW = rw;
        WriteAddressW = wa;
        writeDataW = wd;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0] = ($urandom_range(0, 19) == 0) ? 7'h7F : Ops[$urandom_range(0, 9)];
        ins[11:7] = 5'($urandom_range(0, 4));
        ins[19:15] = 5'($urandom_range(0, 4));
        ins[24:20] = 5'($urandom_range(0, 4));
        return ins;
    endfunction

    initial begin
        bit holdF;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        PCF = 32'h0000_1000;
        #12;
        check("reset E", actualE(), '0);
        check("reset StallF", StallF, 1'b0);
        check("reset ValidE16", validE16, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset E", actualE(), expE);

        setIn(32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF); cycle();
        setIn(AddX5X1X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("wb rd1", ReadOut1E, 32'hDEADBEEF);
        check("wb rd2", ReadOut2E, 32'hDEADBEEF);
        check("wb alu", ALUSelectE, 6'b000000);
        check("wb regwrite", RegWriteE, 1'b1);
        check("wb rd", WriteAddressE, 5'd5);

        setIn(AddiX6X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("addi imm", ImmGenOutE, 32'h0000000A);
        check("addi immsel", ImmSelectE, 1'b1);
        setIn(SwM4, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("sw imm", ImmGenOutE, 32'hFFFFFFFC);
        check("sw memwrite", MemWriteE, 1'b1);
        check("sw regwrite", RegWriteE, 1'b0);
        setIn(LuiX7, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("lui imm", ImmGenOutE, 32'h12345000);
        check("lui alu", ALUSelectE, 6'b000001);

        setIn(LwX3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        setIn(AddX4X3X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("lu stall", stallObs, 1'b1);
        check("lu bubble", ValidE, 1'b0);
        cycle();
        check("lu release", stallObs, 1'b0);
        check("lu add valid", ValidE, 1'b1);
        check("lu add rd", WriteAddressE, 5'd4);
        setIn(LwX3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        setIn(AddiX4X0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("no-use stall", stallObs, 1'b0);
        check("no-use valid", ValidE, 1'b1);

        setIn(JalX1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0); cycle();
        check("flush valid", ValidE, 1'b0);
        check("flush regwrite", RegWriteE, 1'b0);
        check("flush stall", stallObs, 1'b0);
        setIn(LwX3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        setIn(AddX4X3X1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0); cycle();
        check("flush in stall", stallObs, 1'b0);
        check("flush in stall valid", ValidE, 1'b0);

        setIn(32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44444444); cycle();
        setIn(AddX17, 1'b1, 1'b0, 1'b1, 5'd20, 32'h55555555); cycle();
        check("rv32e illegal", illegalE16, 1'b1);
        check("rv32e regwrite", regWriteE16, 1'b0);
        check("rv32e valid", validE16, 1'b1);
        setIn(AddX5X4X0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("rv32e x4 kept", readOut1E16, 32'h44444444);

        setIn(LwX3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        setIn(AddX4X3X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        check("pre-reset stall", StallF, 1'b1);
        reset = 1'b0;
        #1;
        check("reset mid E", actualE(), '0);
        check("reset mid StallF", StallF, 1'b0);
        check("reset mid E16", validE16, 1'b0);
        expE = '0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        ValidF = 1'b0;
        RegWriteW = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release StallF", StallF, 1'b0);
        check("release ValidE", ValidE, 1'b0);
        @(posedge clk);
        #1;
        check("release E", actualE(), expE);
        setIn(AddX5X1X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); cycle();
        check("x1 cleared", ReadOut1E, 32'h0);

        holdF = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!holdF) begin
                instructionF = randInstr();
                PCF = $urandom & 32'hFFFF_FFFC;
                ValidF = ($urandom_range(0, 9) != 0);
            end
            FlushD = ($urandom_range(0, 9) == 0);
            RegWriteW = 1'($urandom_range(0, 1));
            WriteAddressW = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                         : 5'($urandom_range(0, 4));
            writeDataW = $urandom;
            cycle();
            holdF = expStall;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised successor to the fixed-width RV32I decode cycle. Contains:
- the register file;
- immediate generation and control decode;
- the ID/EX pipeline register;
- load-use hazard detection and flush/stall control.

It sits between fetch and execute. It adds configurable data width and register count (RV32I/RV32E), valid tracking, bubble insertion and illegal-instruction flagging, none of which the previous generation has.

## Interface
Parameters:
- XLEN, 32, data/PC width (32 or 64); immediates sign-extend to XLEN
- REG_COUNT, 32, architectural registers (32 = RV32I, 16 = RV32E); ADDR_W = $clog2(REG_COUNT)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- instructionF  in  32  instruction from fetch
- PCF  in  XLEN  PC of instructionF
- ValidF  in  1  instructionF is a real instruction
- FlushD  in  1  taken branch/jump in E: squash the instruction now in decode
- RegWriteW  in  1  writeback enable
- WriteAddressW  in  5  writeback register index
- writeDataW  in  XLEN  writeback data
- StallF  out  1  combinational: hold fetch (PC and instructionF)
- ValidE, RegWriteE, MemReadE, MemWriteE, JtypeE, BranchE, PCSelectE, ImmSelectE, IllegalE  out  1 each  registered E-stage controls
- ALUSelectE  out  6  ALU operation
- WriteAddressE  out  5  rd
- ReadOut1E, ReadOut2E, ImmGenOutE, PCE  out  XLEN  operands, immediate and PC

## Operation
Register file:
- x0 reads 0; writes to x0 are dropped.
- Writes with WriteAddressW >= REG_COUNT are dropped.

Decode:
- Supported opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
- Immediate formats: I, S, B, U and J, selected by opcode; ImmGenOutE = 0 for R-type.
- ImmSelectE = 1 when ALU operand B is the immediate: all formats except R-type and BRANCH.
- PCSelectE = 1 when operand A is the PC: AUIPC, JAL, BRANCH.
- JtypeE = 1 for JAL and JALR; BranchE = 1 for BRANCH.
- ALUSelectE encoding:
  - R-type: {funct7[0], funct7[5], funct3, 0}.
  - OP-IMM: {0, funct7[5] only when funct3 = 101, funct3, 0}.
  - BRANCH: {1, 0, funct3, 0}.
  - LUI: 000001 (pass B).
  - All others: 000000 (add).
- RegWriteE = 1 for every supported opcode except STORE and BRANCH.
- RegWriteE is forced 0 when rd = x0.

Illegal instructions:
- Triggers: unsupported opcode, or any used rs1/rs2/rd index >= REG_COUNT.
- Response: IllegalE = 1 and ValidE = 1; RegWriteE, MemReadE, MemWriteE, JtypeE and BranchE are forced 0.

Load-use hazard:
- Condition: ValidE and MemReadE and WriteAddressE != 0, and WriteAddressE matches a source that instructionF actually uses. rs2 is unused for I/U/J formats; rs1 is unused for U/J formats.
- Response: StallF = 1. The E register loads a bubble. Decode re-presents the same instruction next cycle.

Bubble:
- ValidE = 0, and all control outputs = 0.
- Data outputs are don't-care but must be deterministic; implement as 0.

Priority when several conditions hold:
- FlushD is highest: the E register loads a bubble and StallF = 0.
- Load-use stall comes next.
- ValidF = 0 otherwise loads a bubble.

## Timing
- Latency is 1 cycle: instructionF/PCF sampled at edge N appear on the E outputs after edge N.
- StallF is combinational from the E register and instructionF, so it is valid in the same cycle.
- Regfile write at edge N is visible to a decode read sampled at edge N+1 (no bypass build).
- While reset is low, all E outputs are 0, ValidE = 0, StallF = 0, and every register reads 0.
- Reset deasserted mid-stall: the first cycle after release is clean (ValidE = 0) and no stall is carried over.
- A stall lasts exactly one cycle: after the bubble, MemReadE = 0, so the hazard condition clears.
- FlushD during a stall cycle: the bubble is loaded and StallF drops the same cycle.

## Configuration
- DECODE_WB_BYPASS_EN defined: a writeback in the same cycle as a decode read (RegWriteW, WriteAddressW matches the source, WriteAddressW != 0) forwards writeDataW into ReadOut1E/ReadOut2E at that edge. WB→D is then 0-gap.
- DECODE_WB_BYPASS_EN undefined: the read returns the old register value. The hazard unit/compiler must then provide one cycle of separation.

## Test plan
- WB sequence (reset high):
  - Write x1 = DEADBEEF, then decode ADD x5,x1,x1 the next cycle → ReadOut1E = ReadOut2E = DEADBEEF, ALUSelectE = 000000, RegWriteE = 1, WriteAddressE = 5.
  - With the bypass macro, issuing both in the same cycle gives the same result.
- Immediate checks:
  - ADDI x6,x1,10 → ImmGenOutE = 0000000A, ImmSelectE = 1.
  - SW (imm = −4) → ImmGenOutE = FFFFFFFC, MemWriteE = 1, RegWriteE = 0.
  - LUI x7,0x12345 → ImmGenOutE = 12345000, ALUSelectE = 000001.
- Load-use hazard: LW x3,0(x2) then ADD x4,x3,x1 → StallF = 1 for one cycle, ValidE = 0 for that cycle, then the ADD appears with ValidE = 1. A following ADDI x4,x0,1 (no use of x3) causes no stall.
- FlushD asserted with JAL x1,16 in decode → next-cycle ValidE = 0, RegWriteE = 0, StallF = 0.
- REG_COUNT = 16 build: ADD x17,x1,x2 → IllegalE = 1, RegWriteE = 0. WB to x20 is ignored; x4 reads unchanged.
- Reset low mid-stream (during a stall) → all outputs 0 immediately. After release, x1 reads 0 and StallF = 0.
